// File: rtl/nn_pkg.sv
// Shared widths, derived counts and loader state encoding for the skin-classifier network.
// The network top and the weight loader both size their weight buses from these values.
package nn_pkg;

    localparam int WORD_W  = 17;
    localparam int N_IN    = 7;
    localparam int N_HID   = 13;
    localparam int N_W2    = N_IN * N_HID;
    localparam int N_WORDS = N_W2 + N_HID;
    localparam int CNT_W   = $clog2(N_WORDS + 1);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_COMMIT
    } loader_state_e;

endpackage

// File: rtl/nn_chk_acc.sv
// Running modulo-2^WORD_W sum of accepted weight words, compared against the trailing
// checksum word. Only instantiated when NN_LOADER_CHECKSUM_EN is defined.
module nn_chk_acc
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              add_en,
    input  logic [WORD_W-1:0] data,
    output logic [WORD_W-1:0] sum
);

    logic [WORD_W-1:0] sum_q;

    // Clear wins over add so a restarted load never inherits a partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (clr) begin
            sum_q <= '0;
        end else if (add_en) begin
            sum_q <= sum_q + data;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/nn_weight_loader.sv
// Serial weight loader: streams 104 words into shadow registers, then commits them atomically
// to the live w2/w3 buses. Optional trailing checksum word when NN_LOADER_CHECKSUM_EN is defined.
module nn_weight_loader
    import nn_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [WORD_W-1:0]             s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [WORD_W*N_IN*N_HID-1:0]  w2_bus,
    output logic [WORD_W*N_HID-1:0]       w3_bus,
    output logic                          busy,
    output logic                          done,
    output logic                          weights_valid,
    output logic                          err
);

    loader_state_e                     state_q;
    logic [CNT_W-1:0]                  cnt_q;
    logic [N_WORDS-1:0][WORD_W-1:0]    shadow_q;
    logic [N_WORDS-1:0][WORD_W-1:0]    live_q;
    logic                              s_ready_q;
    logic                              busy_q;
    logic                              done_q;
    logic                              valid_q;
    logic                              accept;

    // A start in the same cycle as a presented word aborts instead of accepting it.
    assign accept = s_valid && s_ready_q && !start;

`ifdef NN_LOADER_CHECKSUM_EN
    logic              err_q;
    logic [WORD_W-1:0] acc_sum;

    nn_chk_acc u_chk_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start && (state_q != ST_COMMIT)),
        .add_en (accept && (state_q == ST_LOAD)),
        .data   (s_data),
        .sum    (acc_sum)
    );

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Word 0 lands in the most significant slot so the packed shadow maps directly onto {w2, w3}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            live_q    <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
`ifdef NN_LOADER_CHECKSUM_EN
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_LOAD;
                        cnt_q     <= '0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef NN_LOADER_CHECKSUM_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (start) begin
                        cnt_q <= '0;
                    end else if (accept) begin
                        shadow_q[LAST_IDX - cnt_q] <= s_data;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) begin
`ifdef NN_LOADER_CHECKSUM_EN
                            state_q   <= ST_CHECK;
`else
                            state_q   <= ST_COMMIT;
                            s_ready_q <= 1'b0;
`endif
                        end
                    end
                end
`ifdef NN_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end else if (accept) begin
                        s_ready_q <= 1'b0;
                        if (s_data == acc_sum) begin
                            state_q <= ST_COMMIT;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                ST_COMMIT: begin
                    live_q  <= shadow_q;
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    s_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign {w2_bus, w3_bus} = live_q;
    assign s_ready          = s_ready_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign weights_valid    = valid_q;

endmodule
